// File: rtl/reg_write_if.sv
// Requester, register-file write and hazard-lookup signals of reg_write_arbiter.
// master = requester/decode side, slave = the arbiter.
interface reg_write_if;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic [15:0] wr_count;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output rd_addr1, rd_addr2,
        input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, hazard1, hazard2, wr_count
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  rd_addr1, rd_addr2,
        output req0_ready, req1_ready, wr_en, wr_addr, wr_data, hazard1, hazard2, wr_count
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter with one slot per requester and hazard lookup.
// Define RR_ARBITRATION_EN for round-robin grants; otherwise requester 0 has fixed priority.
module reg_write_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    reg_write_if.slave  bus
);

    // Reset asserts asynchronously and releases on the first clk edge after rst_n rises.
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    logic [1:0]  slot_valid_q, slot_valid_d;
    logic [4:0]  slot_addr_q [2];
    logic [4:0]  slot_addr_d [2];
    logic [31:0] slot_data_q [2];
    logic [31:0] slot_data_d [2];
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [1:0]  grant;
    logic [1:0]  in_valid;
    logic [4:0]  in_addr [2];
    logic [31:0] in_data [2];

    always_comb begin
        in_valid   = {bus.req1_valid, bus.req0_valid};
        in_addr[0] = bus.req0_addr;
        in_addr[1] = bus.req1_addr;
        in_data[0] = bus.req0_data;
        in_data[1] = bus.req1_data;
    end

`ifdef RR_ARBITRATION_EN
    // Requester favoured on the next contended cycle; moves only when a grant happens.
    logic prio_q, prio_d;

    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        if (slot_valid_q == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end else begin
            grant = slot_valid_q;
        end
        if (grant != 2'b00) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        grant    = 2'b00;
        grant[0] = slot_valid_q[0];
        grant[1] = slot_valid_q[1] & ~slot_valid_q[0];
    end
`endif

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_count_d   = wr_count_q;
        for (int i = 0; i < 2; i++) begin
            // A slot empty at this edge may load; a slot granted now only reopens next cycle.
            if (!slot_valid_q[i] && in_valid[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_addr_d[i]  = in_addr[i];
                slot_data_d[i]  = in_data[i];
            end
            if (grant[i]) begin
                slot_valid_d[i] = 1'b0;
                wr_en_d         = 1'b1;
                wr_addr_d       = slot_addr_q[i];
                wr_data_d       = slot_data_q[i];
                wr_count_d      = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            slot_valid_q <= 2'b00;
            slot_addr_q  <= '{default: '0};
            slot_data_q  <= '{default: '0};
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_count_q   <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Pending writes are every occupied slot plus the write currently on the port.
    function automatic logic pending_hit(input logic [4:0] rd);
        return (slot_valid_q[0] && slot_addr_q[0] == rd)
            || (slot_valid_q[1] && slot_addr_q[1] == rd)
            || (wr_en_q && wr_addr_q == rd);
    endfunction

    always_comb begin
        bus.req0_ready = ~slot_valid_q[0];
        bus.req1_ready = ~slot_valid_q[1];
        bus.wr_en      = wr_en_q;
        bus.wr_addr    = wr_addr_q;
        bus.wr_data    = wr_data_q;
        bus.wr_count   = wr_count_q;
        bus.hazard1    = pending_hit(bus.rd_addr1);
        bus.hazard2    = pending_hit(bus.rd_addr2);
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomised bench for reg_write_arbiter: a slot-level reference model feeds a write scoreboard.
module tb_reg_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    reg_write_if bus ();

    reg_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [15:0] count;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    // Reference model: per-requester pending write, last granted requester, write port.
    bit          m_v [2];
    logic [4:0]  m_a [2];
    logic [31:0] m_d [2];
    int          m_last;
    bit          m_en;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [15:0] m_cnt;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_v[0] = 0; m_v[1] = 0;
        m_a[0] = 0; m_a[1] = 0;
        m_d[0] = 0; m_d[1] = 0;
        m_last = 1;
        m_en = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
        exp_q.delete();
    endfunction

    function automatic bit exp_haz(input logic [4:0] r);
        return (m_v[0] && m_a[0] == r) || (m_v[1] && m_a[1] == r) || (m_en && m_wa == r);
    endfunction

    // Check outputs at the falling edge, drive the next inputs, then advance the model
    // to what the following rising edge should produce.
    task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit ld0, ld1;
        int g;
        @(negedge clk);
        check("wr_en", bus.wr_en, m_en);
        check("wr_addr", bus.wr_addr, m_wa);
        check("wr_data", bus.wr_data, m_wd);
        check("wr_count", bus.wr_count, m_cnt);
        check("req0_ready", bus.req0_ready, !m_v[0]);
        check("req1_ready", bus.req1_ready, !m_v[1]);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        bus.rd_addr1 = r1; bus.rd_addr2 = r2;
        #1;
        check("hazard1", bus.hazard1, exp_haz(r1));
        check("hazard2", bus.hazard2, exp_haz(r2));
        ld0 = v0 && !m_v[0];
        ld1 = v1 && !m_v[1];
        g = -1;
        if (m_v[0] && m_v[1]) begin
`ifdef RR_ARBITRATION_EN
            g = 1 - m_last;
`else
            g = 0;
`endif
        end else if (m_v[0]) begin
            g = 0;
        end else if (m_v[1]) begin
            g = 1;
        end
        if (g >= 0) begin
            m_en = 1; m_wa = m_a[g]; m_wd = m_d[g]; m_cnt = m_cnt + 16'd1;
            m_v[g] = 0; m_last = g;
            exp_q.push_back({m_wa, m_wd, m_cnt});
        end else begin
            m_en = 0;
        end
        if (ld0) begin m_v[0] = 1; m_a[0] = a0; m_d[0] = d0; end
        if (ld1) begin m_v[1] = 1; m_a[1] = a1; m_d[1] = d1; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 5'd31, 5'd31);
    endtask

    task automatic release_reset();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    // Pull reset low between edges and confirm outputs clear without a clock edge.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst wr_en", bus.wr_en, 0);
        check("rst wr_addr", bus.wr_addr, 0);
        check("rst wr_data", bus.wr_data, 0);
        check("rst wr_count", bus.wr_count, 0);
        check("rst req0_ready", bus.req0_ready, 1);
        check("rst req1_ready", bus.req1_ready, 1);
        check("rst hazard1", bus.hazard1, 0);
        check("rst hazard2", bus.hazard2, 0);
        release_reset();
    endtask

    // Scoreboard monitor: every issued write must match the oldest predicted one.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got write addr=%0h data=%0h expected none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_addr", bus.wr_addr, mon_e.addr);
                check("sb_data", bus.wr_data, mon_e.data);
                check("sb_count", bus.wr_count, mon_e.count);
            end
        end
    end

    initial begin
        bit wrapped;
        logic [15:0] prev;
        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
        bus.rd_addr1 = 0; bus.rd_addr2 = 0;
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("init wr_en", bus.wr_en, 0);
        check("init wr_count", bus.wr_count, 0);
        check("init req0_ready", bus.req0_ready, 1);
        check("init req1_ready", bus.req1_ready, 1);
        check("init hazard1", bus.hazard1, 0);
        release_reset();

        // Single write from requester 0.
        step(1, 5'd5, 32'h9, 0, 0, 0, 5'd5, 5'd0);
        step(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        step(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        check("single wr_addr", bus.wr_addr, 5);
        check("single wr_data", bus.wr_data, 9);
        check("single wr_count", bus.wr_count, 1);
        check("single wr_en", bus.wr_en, 1);
        idle(2);

        // Both requesters held continuously with fresh data.
        for (int i = 0; i < 8; i++) step(1, 5'd3, 32'hA + i, 1, 5'd4, 32'hB + i, 5'd3, 5'd4);
        idle(3);

        // Slot 1 pending on address 7 drives hazard2 only.
        step(0, 0, 0, 1, 5'd7, 32'h77, 5'd6, 5'd7);
        step(0, 0, 0, 0, 0, 0, 5'd6, 5'd7);
        check("slot1 hazard2", bus.hazard2, 1);
        check("slot1 hazard1", bus.hazard1, 0);
        idle(3);

        // Same address from both requesters, including address 0.
        step(1, 5'd2, 32'h1, 1, 5'd2, 32'h2, 5'd2, 5'd0);
        idle(3);
        step(1, 5'd0, 32'h10, 1, 5'd0, 32'h20, 5'd0, 5'd0);
        idle(3);

        // Reset with both slots occupied discards them.
        step(1, 5'd10, 32'hDEAD, 1, 5'd11, 32'hBEEF, 5'd10, 5'd11);
        step(0, 0, 0, 0, 0, 0, 5'd10, 5'd11);
        mid_reset();
        idle(4);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (i == 700) mid_reset();
        end

        // Saturate both requesters until wr_count wraps.
        wrapped = 0;
        prev = bus.wr_count;
        for (int i = 0; i < 70000 && !wrapped; i++) begin
            step(1, 5'($urandom_range(0, 31)), $urandom, 1, 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (prev == 16'hFFFF && bus.wr_count == 16'h0000) wrapped = 1;
            prev = bus.wr_count;
        end
        check("count wrap", wrapped, 1);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
